tile_stream_unit: RTL and testbench



---
 rtl/tile_stream_unit_if.sv | 27 ++
 rtl/tile_stream_unit.sv | 119 +++++++++++
 tb/tb_tile_stream_unit.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_stream_unit_if.sv
// tile_stream_unit_if: vector-in / beat-out handshake bundle for tile_stream_unit.
// master drives the input vector, config and out_ready; slave is the engine.
interface tile_stream_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_ELEMS   = 64,
    parameter int LANES      = 16,
    parameter int RW         = 3
);
    logic [IN_ELEMS*DATA_WIDTH-1:0] in_data;
    logic                           in_valid;
    logic                           in_ready;
    logic                           cfg_mode;
    logic [RW-1:0]                  cfg_repeat;
    logic [LANES*DATA_WIDTH-1:0]    out_data;
    logic                           out_valid;
    logic                           out_ready;
    logic                           out_last;
    logic                           cfg_err;
    modport master (
        output in_data, in_valid, cfg_mode, cfg_repeat, out_ready,
        input  in_ready, out_data, out_valid, out_last, cfg_err
    );
    modport slave (
        input  in_data, in_valid, cfg_mode, cfg_repeat, out_ready,
        output in_ready, out_data, out_valid, out_last, cfg_err
    );
endinterface

// File: rtl/tile_stream_unit.sv
// tile_stream_unit: streams one vector out as element-repeated or block-tiled beats.
// Defining TILE_PREFETCH_EN adds a shadow input register for bubble-free back-to-back vectors.
module tile_stream_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_ELEMS   = 64,
    parameter int LANES      = 16,
    parameter int MAX_REPEAT = 4
) (
    input logic clk,
    input logic rst_n,
    tile_stream_unit_if.slave bus
);
    localparam int RW  = $clog2(MAX_REPEAT + 1);
    localparam int VW  = IN_ELEMS * DATA_WIDTH;
    localparam int XW  = $clog2(VW);
    localparam int BPV = IN_ELEMS / LANES;
    localparam int BW  = $clog2(BPV * MAX_REPEAT + 1);

    typedef enum logic {IDLE, STREAM} state_t;
    state_t state_q, state_d;

    logic [VW-1:0]            vec, nxt_vec;
    logic                     mode, nxt_mode;
    logic [RW-1:0]            rep, nxt_rep, eff;
    logic [BW-1:0]            beat, last_b;
    logic [LANES*DATA_WIDTH-1:0] obeat;
    logic bad, in_ready, accept, streaming, beat_hs, done, load_in, load_sh, err;

    assign bad       = bus.cfg_repeat == '0 || bus.cfg_repeat > RW'(MAX_REPEAT);
    assign eff       = bus.cfg_repeat == '0 ? RW'(1) : bad ? RW'(MAX_REPEAT) : bus.cfg_repeat;
    assign streaming = state_q == STREAM;
    assign last_b    = BW'(BPV * int'(rep) - 1);
    assign beat_hs   = streaming && bus.out_ready;
    assign done      = beat_hs && bus.out_last;
    assign accept    = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = streaming;
    assign bus.out_last  = streaming && beat == last_b;
    assign bus.out_data  = obeat;
    assign bus.cfg_err   = err;

`ifdef TILE_PREFETCH_EN
    logic [VW-1:0] sh_vec;
    logic          sh_mode, sh_full;
    logic [RW-1:0] sh_rep;
    // A vector arriving with the last beat bypasses the shadow and goes straight to STREAM.
    assign in_ready = !streaming || !sh_full;
    assign load_in  = accept && (!streaming || done);
    assign load_sh  = done && sh_full;
    assign nxt_vec  = load_sh ? sh_vec : bus.in_data;
    assign nxt_mode = load_sh ? sh_mode : bus.cfg_mode;
    assign nxt_rep  = load_sh ? sh_rep : eff;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sh_vec  <= '0;
            sh_mode <= 1'b0;
            sh_rep  <= RW'(1);
            sh_full <= 1'b0;
        end else if (accept && streaming && !done) begin
            sh_vec  <= bus.in_data;
            sh_mode <= bus.cfg_mode;
            sh_rep  <= eff;
            sh_full <= 1'b1;
        end else if (load_sh) begin
            sh_full <= 1'b0;
        end
`else
    assign in_ready = !streaming;
    assign load_in  = accept;
    assign load_sh  = 1'b0;
    assign nxt_vec  = bus.in_data;
    assign nxt_mode = bus.cfg_mode;
    assign nxt_rep  = eff;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q;
        if (load_in || load_sh) state_d = STREAM;
        else if (done) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vec  <= '0;
            mode <= 1'b0;
            rep  <= RW'(1);
            beat <= '0;
            err  <= 1'b0;
        end else begin
            err <= accept && bad;
            if (load_in || load_sh) begin
                vec  <= nxt_vec;
                mode <= nxt_mode;
                rep  <= nxt_rep;
                beat <= '0;
            end else if (beat_hs) begin
                beat <= beat + BW'(1);
            end
        end

    // Element-repeat divides by a constant per legal R, selected by the registered factor.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        int k, q, src;
        logic [XW-1:0] base;
        always_comb begin
            k = int'(beat) * LANES + l;
            q = k;
            for (int r = 2; r <= MAX_REPEAT; r++) q = int'(rep) == r ? k / r : q;
            src  = mode ? k % IN_ELEMS : q;
            base = XW'(src * DATA_WIDTH);
        end
        assign obeat[l*DATA_WIDTH +: DATA_WIDTH] = streaming ? vec[base +: DATA_WIDTH] : '0;
    end
endmodule

// File: tb/tb_tile_stream_unit.sv
// tb_tile_stream_unit: scoreboard bench for tile_stream_unit (DW=16, IE=8, LANES=4, MAX_REPEAT=4).
// Define TILE_PREFETCH_EN to expect the bubble-free back-to-back handoff.
module tb_tile_stream_unit;
    localparam int DW = 16, IE = 8, LN = 4, MR = 4, RW = 3;
    localparam int LW = LN * DW;
`ifdef TILE_PREFETCH_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif
    localparam bit [3:0] TM = 4'b0110;
    localparam bit [3:0] TE = 4'b1100;
    localparam int TR [4] = '{2, 3, 0, 7};
    localparam int TN [4] = '{4, 6, 2, 8};
    localparam logic [LW-1:0] TB0 [4] = '{64'h0011_0011_0010_0010, 64'h0013_0012_0011_0010,
                                          64'h0013_0012_0011_0010, 64'h0010_0010_0010_0010};

    typedef struct packed {
        logic [LW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [IE*DW-1:0] vec_in;
    beat_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    tile_stream_unit_if #(.DATA_WIDTH(DW), .IN_ELEMS(IE), .LANES(LN), .RW(RW)) bus ();
    tile_stream_unit #(.DATA_WIDTH(DW), .IN_ELEMS(IE), .LANES(LN), .MAX_REPEAT(MR)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic void expect_vec(input bit m, input int r);
        int er, nb, k;
        beat_t t;
        er = r == 0 ? 1 : (r > MR ? MR : r);
        nb = IE * er / LN;
        for (int b = 0; b < nb; b++) begin
            t = '0;
            for (int l = 0; l < LN; l++) begin
                k = b * LN + l;
                t.data[l*DW +: DW] = 16'(32'h10 + (m ? k % IE : k / er));
            end
            t.last = b == nb - 1;
            sb.push_back(t);
        end
    endfunction

    function automatic beat_t pop_exp();
        if (sb.size() == 0) return '0;
        return sb.pop_front();
    endfunction

    // Offer a vector, wait (bounded) for acceptance, then scramble inputs.
    task automatic send(input bit m, input int r, output bit ok);
        bus.in_data = vec_in;
        bus.cfg_mode = m;
        bus.cfg_repeat = RW'(r);
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready === 1'b1;
        end
        @(posedge clk);
        if (ok) expect_vec(m, r);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL send_accept: in_ready got %b, want 1 within 50 cycles", bus.in_ready);
        end
        #1;
        bus.in_valid = 1'b0;
        bus.in_data = ~vec_in;
        bus.cfg_mode = !m;
        bus.cfg_repeat = '1;
    endtask

    task automatic test_reset;
        #12;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== '0 ||
            bus.cfg_err !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: got v=%b l=%b d=%h e=%b rdy=%b, want v=0 l=0 d=0 e=0 rdy=1",
                     bus.out_valid, bus.out_last, bus.out_data, bus.cfg_err, bus.in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_modes;
        for (int i = 0; i < 4; i++) begin
            bit ok, fin;
            int seen;
            beat_t e;
            send(TM[i], TR[i], ok);
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== TB0[i] || bus.cfg_err !== TE[i]) begin
                miscompares++;
                $display("FAIL mode%0d_first: got v=%b d=%h err=%b, want v=1 d=%h err=%b",
                         i, bus.out_valid, bus.out_data, bus.cfg_err, TB0[i], TE[i]);
            end
            seen = 0;
            fin = 1'b0;
            for (int c = 0; c < 20 && !fin; c++) begin
                if (c > 0) @(negedge clk);
                if (c == 1) begin
                    vectors++;
                    if (bus.cfg_err !== 1'b0) begin
                        miscompares++;
                        $display("FAIL mode%0d_err_pulse: got %b, want 0", i, bus.cfg_err);
                    end
                end
                if (bus.out_valid === 1'b1) begin
                    e = pop_exp();
                    seen++;
                    fin = bus.out_last === 1'b1;
                    vectors++;
                    if (bus.out_data !== e.data || bus.out_last !== e.last) begin
                        miscompares++;
                        $display("FAIL mode%0d_beat%0d: got d=%h l=%b, want d=%h l=%b",
                                 i, seen - 1, bus.out_data, bus.out_last, e.data, e.last);
                    end
                end
            end
            vectors++;
            if (seen !== TN[i] || sb.size() !== 0) begin
                miscompares++;
                $display("FAIL mode%0d_count: got %0d beats (%0d left), want %0d",
                         i, seen, sb.size(), TN[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        beat_t e;
        send(1'b0, 2, ok);
        @(negedge clk);
        e = pop_exp();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_last !== e.last) begin
            miscompares++;
            $display("FAIL bp_beat0: got v=%b d=%h, want v=1 d=%h", bus.out_valid, bus.out_data, e.data);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h0013_0013_0012_0012 ||
                bus.out_last !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v=%b d=%h l=%b, want v=1 d=0013001300120012 l=0",
                         s, bus.out_valid, bus.out_data, bus.out_last);
            end
            @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
        for (int b = 1; b < 4; b++) begin
            @(negedge clk);
            e = pop_exp();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_last !== e.last) begin
                miscompares++;
                $display("FAIL bp_beat%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                         b, bus.out_valid, bus.out_data, bus.out_last, e.data, e.last);
            end
            @(posedge clk);
        end
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || sb.size() !== 0) begin
            miscompares++;
            $display("FAIL bp_end: got v=%b left=%0d, want v=0 left=0", bus.out_valid, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_stream;
        bit ok;
        beat_t e;
        send(1'b1, 2, ok);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            e = pop_exp();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_last !== e.last) begin
                miscompares++;
                $display("FAIL rst_pre_beat%0d: got v=%b d=%h, want v=1 d=%h",
                         b, bus.out_valid, bus.out_data, e.data);
            end
            if (b < 2) @(posedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: got v=%b d=%h l=%b, want 0 0 0",
                     bus.out_valid, bus.out_data, bus.out_last);
        end
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_release: got v=%b rdy=%b, want v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        send(1'b0, 1, ok);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            e = pop_exp();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_last !== e.last) begin
                miscompares++;
                $display("FAIL rst_post_beat%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                         b, bus.out_valid, bus.out_data, bus.out_last, e.data, e.last);
            end
            @(posedge clk);
        end
        #1;
    endtask

    task automatic test_back_to_back;
        bit oka, okb;
        int n;
        int cyc[4];
        beat_t e;
        n = 0;
        cyc = '{default: 0};
        fork
            begin
                send(1'b1, 1, oka);
                send(1'b1, 1, okb);
            end
            begin
                for (int c = 0; c < 30 && n < 4; c++) begin
                    @(negedge clk);
                    if (bus.out_valid === 1'b1) begin
                        e = pop_exp();
                        vectors++;
                        if (bus.out_data !== e.data || bus.out_last !== e.last) begin
                            miscompares++;
                            $display("FAIL b2b_beat%0d: got d=%h l=%b, want d=%h l=%b",
                                     n, bus.out_data, bus.out_last, e.data, e.last);
                        end
                        cyc[n] = c;
                        n++;
                    end
                end
            end
        join
        vectors++;
        if (n !== 4 || cyc[2] - cyc[1] !== GAP) begin
            miscompares++;
            $display("FAIL b2b_gap: got %0d beats gap=%0d, want 4 beats gap=%0d",
                     n, cyc[2] - cyc[1], GAP);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < IE; i++) vec_in[i*DW +: DW] = 16'(32'h10 + i);
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.cfg_mode = 1'b0;
        bus.cfg_repeat = '0;
        bus.out_ready = 1'b1;
        test_reset;
        test_modes;
        test_backpressure;
        test_reset_mid_stream;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
